// File: rtl/muldiv_sequencer_pkg.sv
// Shared encodings for the multi-cycle multiply/divide sequencer.
package muldiv_sequencer_pkg;

  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_MULHU = 2'b01,
    OP_DIVU  = 2'b10,
    OP_REMU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/addsub_ext.sv
// W-bit ripple adder/subtractor from full_adder cells; cout=1 on subtract means no borrow.
module addsub_ext #(
  parameter int W = 33
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         sub,
  output logic [W-1:0] s,
  output logic         cout
);

  logic [W:0]   c;
  logic [W-1:0] y_eff;

  assign c[0]  = sub;
  assign y_eff = y ^ {W{sub}};

  for (genvar i = 0; i < W; i++) begin : g_fa
    full_adder u_fa (
      .a   (x[i]),
      .b   (y_eff[i]),
      .cin (c[i]),
      .s   (s[i]),
      .cout(c[i+1])
    );
  end

  assign cout = c[W];

endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell used to build the ripple adder/subtractor.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU: one shared adder, one bit per CALC cycle.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             dbz_q, dbz_d;

  // acc holds hi (multiply) or rem (divide); sh holds lo or quot; opnd holds mcand or dvsr.
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;

  logic [WIDTH:0]   add_x, add_y, add_s;
  logic             add_sub, add_co;
  logic [WIDTH-1:0] it_acc, it_sh, div_t;
  logic             accept, zero_div;

  always_comb begin
    div_t = {acc_q[WIDTH-2:0], sh_q[WIDTH-1]};
    if (op_q[1]) begin
      add_x   = {acc_q, sh_q[WIDTH-1]};
      add_y   = {1'b0, opnd_q};
      add_sub = 1'b1;
    end else begin
      add_x   = {1'b0, acc_q};
      add_y   = {1'b0, (sh_q[0] ? opnd_q : '0)};
      add_sub = 1'b0;
    end
  end

  addsub_ext #(.W(WIDTH + 1)) u_addsub (
    .x   (add_x),
    .y   (add_y),
    .sub (add_sub),
    .s   (add_s),
    .cout(add_co)
  );

  always_comb begin
    if (op_q[1]) begin
      it_acc = add_co ? add_s[WIDTH-1:0] : div_t;
      it_sh  = {sh_q[WIDTH-2:0], add_co};
    end else begin
      it_acc = add_s[WIDTH:1];
      it_sh  = {add_s[0], sh_q[WIDTH-1:1]};
    end
  end

  assign accept   = start && (state_q != S_CALC);
  assign zero_div = op[1] && (b == '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    dbz_d    = dbz_q;
    op_d     = op_q;
    acc_d    = acc_q;
    sh_d     = sh_q;
    opnd_d   = opnd_q;
    case (state_q)
      S_CALC: begin
        acc_d = it_acc;
        sh_d  = it_sh;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          state_d = S_DONE;
          case (op_q)
            OP_MUL:   result_d = it_sh;
            OP_MULHU: result_d = it_acc;
            OP_DIVU:  result_d = it_sh;
            default:  result_d = it_acc;
          endcase
        end
      end
      default: begin
        if (accept) begin
          op_d   = op;
          acc_d  = '0;
          sh_d   = a;
          opnd_d = b;
          cnt_d  = '0;
          dbz_d  = zero_div;
          if (zero_div) begin
            state_d  = S_DONE;
            result_d = (op == OP_DIVU) ? '1 : a;
          end else begin
            state_d = S_CALC;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      dbz_q    <= dbz_d;
    end
  end

  // Datapath registers carry no reset; they are reloaded on every accepted start.
  always_ff @(posedge clk) begin
    op_q   <= op_d;
    acc_q  <= acc_d;
    sh_q   <= sh_d;
    opnd_q <= opnd_d;
  end

  assign busy        = (state_q == S_CALC);
  assign done        = (state_q == S_DONE);
  assign result      = result_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: expectations queued at issue, compared on done.
module tb_muldiv_sequencer;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] res;
    logic         dbz;
    string        tag;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] result;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] x,
                                         input logic [W-1:0] y);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    case (o)
      2'b00:   return p[W-1:0];
      2'b01:   return p[2*W-1:W];
      2'b10:   return (y == '0) ? '1 : x / y;
      default: return (y == '0) ? x : x % y;
    endcase
  endfunction

  // Result scoreboard: every done pops one expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: result=%h with no pending operation", result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (result !== e.res || div_by_zero !== e.dbz) begin
          errors++;
          $display("FAIL %s: result=%h dbz=%b expected result=%h dbz=%b",
                   e.tag, result, div_by_zero, e.res, e.dbz);
        end
      end
    end
  end

  // Called at a negedge; start is sampled at the next posedge (cycle 0), returns in cycle 1.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input string tag);
    exp_t e;
    e.res = model(o, x, y);
    e.dbz = o[1] && (y == '0);
    e.tag = tag;
    sb.push_back(e);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout: done=%b expected 1", tag, done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || div_by_zero !== 1'b0) begin
        errors++;
        $display("FAIL reset_state: busy=%b done=%b result=%h dbz=%b expected 0 0 0 0",
                 busy, done, result, div_by_zero);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_mul_timing();
    issue(2'b00, 32'd7, 32'd6, "mul_7x6");
    for (int c = 1; c <= 33; c++) begin
      checks++;
      if (busy !== (c <= 32) || done !== (c == 33)) begin
        errors++;
        $display("FAIL mul_timing c%0d: busy=%b done=%b expected busy=%b done=%b",
                 c, busy, done, (c <= 32), (c == 33));
      end
      if (c < 33) @(negedge clk);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL mul_done_pulse: done=%b expected 0", done);
    end
  endtask

  task automatic test_mul_max();
    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_max");
    wait_done("mul_max");
    @(negedge clk);
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_max");
    wait_done("mulhu_max");
    @(negedge clk);
    issue(2'b01, 32'hDEAD_BEEF, 32'h1234_5678, "mulhu_mixed");
    wait_done("mulhu_mixed");
    @(negedge clk);
  endtask

  task automatic test_div_by_zero();
    issue(2'b10, 32'd5, 32'd0, "divu_by_zero");
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL divz_latency: done=%b busy=%b expected done=1 busy=0", done, busy);
    end
    issue(2'b11, 32'd5, 32'd0, "remu_by_zero");
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL divz_back_to_back: done=%b expected 1", done);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL divz_idle: done=%b busy=%b expected 0 0", done, busy);
    end
  endtask

  task automatic test_div();
    issue(2'b10, 32'd100, 32'd7, "divu_100_7");
    wait_done("divu_100_7");
    @(negedge clk);
    issue(2'b11, 32'd100, 32'd7, "remu_100_7");
    wait_done("remu_100_7");
    @(negedge clk);
    issue(2'b10, 32'd3, 32'd9, "divu_3_9");
    wait_done("divu_3_9");
    @(negedge clk);
    issue(2'b11, 32'hFFFF_FFFF, 32'h0001_0003, "remu_big");
    wait_done("remu_big");
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    issue(2'b00, 32'd123, 32'd456, "b2b_first");
    repeat (9) @(negedge clk);
    start = 1'b1; op = 2'b10; a = 32'd1; b = 32'd0;
    @(negedge clk);
    start = 1'b0;
    repeat (22) @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first_done_c33: done=%b busy=%b expected 1 0", done, busy);
    end
    issue(2'b01, 32'hDEAD_BEEF, 32'hCAFE_F00D, "b2b_second");
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second_busy_c34: busy=%b done=%b expected 1 0", busy, done);
    end
    repeat (31) @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_early_c65: done=%b expected 0", done);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second_done_c66: done=%b expected 1", done);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    issue(2'b10, 32'd1000, 32'd3, "aborted_div");
    repeat (9) @(negedge clk);
    reset = 1'b1;
    sb.delete(sb.size() - 1);
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || result !== '0 || done !== 1'b0 || div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_op_c11: busy=%b result=%h done=%b dbz=%b expected 0 0 0 0",
               busy, result, done, div_by_zero);
    end
    for (int c = 11; c <= 40; c++) begin
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_done c%0d: done=%b busy=%b expected 0 0", c, done, busy);
      end
      @(negedge clk);
    end
    issue(2'b10, 32'd100, 32'd7, "divu_after_reset");
    wait_done("divu_after_reset");
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_mul_timing();
    test_mul_max();
    test_div_by_zero();
    test_div();
    test_back_to_back();
    test_reset_mid_op();
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: pending=%0d expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
